cond_branch_unit: RTL and testbench

- Consumer end of the ALU flag interface in the pipelined LEGv8 core.
- Holds the architectural NZCV register, written by flag-setting ALU ops (ADDS/SUBS).
- Evaluates B.cond conditions against NZCV, bypassing same-cycle flags from the older EX instruction.
- Produces a registered taken/not-taken result for the fetch redirect, plus branch and taken performance counters.

---
 rtl/cond_branch_unit.sv | 92 +++++++++
 tb/tb_cond_branch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cond_branch_unit.sv
// Branch condition unit: holds architectural NZCV, evaluates B.cond with a
// same-cycle bypass from the older EX instruction, and registers the outcome.
module cond_branch_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_write_flags,
   input  logic [3:0]       ex_nzcv,
   input  logic             br_valid,
   input  logic             br_is_cond,
   input  logic [3:0]       br_cond,
   input  logic             stall,
   input  logic             flush,
   output logic [3:0]       nzcv_q,
   output logic             taken_valid,
   output logic             taken,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   typedef struct packed {
      logic       is_cond;
      logic [3:0] cond;
   } br_req_t;

   br_req_t    br_req;
   logic       ex_flags;
   logic       flag_we;
   logic       br_acc;
   logic       hold;
   logic [3:0] eff;
   logic       n, z, c, v;
   logic       cond_true;

   assign br_req   = '{is_cond: br_is_cond, cond: br_cond};
   assign ex_flags = ex_valid & ex_write_flags & ~flush;
   assign flag_we  = ex_flags & ~stall;
   assign br_acc   = br_valid & ~stall & ~flush;
   // Flush wins over stall, so only a clean stall freezes the result.
   assign hold     = stall & ~flush;

   // ex_* is always older than br_*, so its flags feed this cycle's branch.
   assign eff          = ex_flags ? ex_nzcv : nzcv_q;
   assign {n, z, c, v} = eff;

   always_comb begin
      cond_true = 1'b1;
      if (br_req.is_cond) begin
         unique case (br_req.cond)
            4'h0:    cond_true = z;
            4'h1:    cond_true = ~z;
            4'h2:    cond_true = c;
            4'h3:    cond_true = ~c;
            4'h4:    cond_true = n;
            4'h5:    cond_true = ~n;
            4'h6:    cond_true = v;
            4'h7:    cond_true = ~v;
            4'h8:    cond_true = c & ~z;
            4'h9:    cond_true = ~(c & ~z);
            4'hA:    cond_true = (n == v);
            4'hB:    cond_true = (n != v);
            4'hC:    cond_true = ~z & (n == v);
            4'hD:    cond_true = ~(~z & (n == v));
            default: cond_true = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nzcv_q       <= '0;
         taken_valid  <= 1'b0;
         taken        <= 1'b0;
         branch_count <= '0;
         taken_count  <= '0;
      end else begin
         if (flag_we) nzcv_q <= ex_nzcv;
         if (br_acc) begin
            taken_valid  <= 1'b1;
            taken        <= cond_true;
            branch_count <= branch_count + CNT_W'(1);
            taken_count  <= taken_count + CNT_W'(cond_true);
         end else if (!hold) begin
            taken_valid <= 1'b0;
            taken       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed plus randomized check of cond_branch_unit against a table-driven
// reference model of the flag register, branch outcome and counters.
module tb_cond_branch_unit;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             ex_valid, ex_write_flags;
   logic [3:0]       ex_nzcv;
   logic             br_valid, br_is_cond;
   logic [3:0]       br_cond;
   logic             stall, flush;
   logic [3:0]       nzcv_q;
   logic             taken_valid, taken;
   logic [CNT_W-1:0] branch_count, taken_count;

   cond_branch_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_write_flags(ex_write_flags), .ex_nzcv(ex_nzcv),
      .br_valid(br_valid), .br_is_cond(br_is_cond), .br_cond(br_cond),
      .stall(stall), .flush(flush),
      .nzcv_q(nzcv_q), .taken_valid(taken_valid), .taken(taken),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   logic [3:0] m_nzcv;
   logic       m_tv, m_tk;
   int         m_bc, m_tc;

   // Pairs of conditions share a base test; odd codes invert it, NV is always.
   function automatic logic ref_cond(logic is_cond, logic [3:0] cond, logic [3:0] f);
      logic n, z, c, v, base;
      if (!is_cond || cond == 4'hF) return 1'b1;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return 1'b1;
      endcase
      return base ^ cond[0];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(string tag);
      chk({tag, ".nzcv"}, 32'(nzcv_q), 32'(m_nzcv));
      chk({tag, ".tv"},   32'(taken_valid), 32'(m_tv));
      chk({tag, ".tk"},   32'(taken), 32'(m_tk));
      chk({tag, ".bc"},   32'(branch_count), 32'(m_bc));
      chk({tag, ".tc"},   32'(taken_count), 32'(m_tc));
   endtask

   task automatic model_reset();
      m_nzcv = 4'h0; m_tv = 1'b0; m_tk = 1'b0; m_bc = 0; m_tc = 0;
   endtask

   task automatic drv(logic ev, logic wf, logic [3:0] nz, logic bv, logic ic,
                      logic [3:0] bc, logic st, logic fl);
      ex_valid = ev; ex_write_flags = wf; ex_nzcv = nz;
      br_valid = bv; br_is_cond = ic; br_cond = bc; stall = st; flush = fl;
   endtask

   task automatic cycle(string tag);
      logic [3:0] eff;
      logic ct;
      @(posedge clk);
      if (!reset) model_reset();
      else begin
         eff = (ex_valid && ex_write_flags && !flush) ? ex_nzcv : m_nzcv;
         ct  = ref_cond(br_is_cond, br_cond, eff);
         if (br_valid && !stall && !flush) begin
            m_tv = 1'b1; m_tk = ct;
            m_bc = (m_bc + 1) % (1 << CNT_W);
            m_tc = (m_tc + int'(ct)) % (1 << CNT_W);
         end else if (!(stall && !flush)) begin
            m_tv = 1'b0; m_tk = 1'b0;
         end
         if (ex_valid && ex_write_flags && !stall && !flush) m_nzcv = ex_nzcv;
      end
      #1 chk_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1 model_reset();
      chk_all("rst_async");
      cycle("rst_hold");
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      drv(0, 0, 4'h0, 1, 1, 4'h0, 0, 0);
      model_reset();
      #2;
      // reset with a branch presented
      do_reset();
      chk("rst_bc_zero", 32'(branch_count), 32'd0);
      drv(0, 0, 4'h0, 1, 1, 4'h0, 0, 0);            // B.EQ, flags 0000
      cycle("eq_noflags");
      chk("eq_noflags_taken", 32'(taken), 32'd0);

      // bypass: Z set by the same-cycle ALU op
      drv(1, 1, 4'h4, 1, 1, 4'h0, 0, 0);
      cycle("bypass_eq");
      chk("bypass_eq_taken", 32'(taken), 32'd1);
      drv(0, 0, 4'h0, 1, 1, 4'h1, 0, 0);
      cycle("ne_after");

      // signed compares
      drv(1, 1, 4'h9, 1, 1, 4'hA, 0, 0); cycle("ge");
      drv(0, 0, 4'h0, 1, 1, 4'hB, 0, 0); cycle("lt");
      drv(0, 0, 4'h0, 1, 1, 4'hC, 0, 0); cycle("gt");
      drv(1, 1, 4'h8, 1, 1, 4'hD, 0, 0); cycle("le");
      chk("le_taken", 32'(taken), 32'd1);

      // stall holds flags and result; flush beats stall
      drv(1, 1, 4'h2, 0, 1, 4'h0, 1, 0); cycle("stall");
      drv(1, 1, 4'h2, 1, 1, 4'h0, 1, 1); cycle("flush_stall");
      chk("flush_stall_tv", 32'(taken_valid), 32'd0);

      // unconditional ignores cond field; NV is always
      drv(1, 1, 4'h4, 1, 0, 4'h1, 0, 0); cycle("uncond");
      drv(0, 0, 4'h0, 1, 1, 4'hF, 0, 0); cycle("nv");

      // counter wrap at 4 bits
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drv(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
         cycle("wrap");
      end
      chk("wrap_bc", 32'(branch_count), 32'd1);
      chk("wrap_tc", 32'(taken_count), 32'd1);

      // randomized traffic with occasional async reset mid-cycle
      for (int i = 0; i < 400; i++) begin
         drv(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 5) != 0), 4'($urandom),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 49) == 0) do_reset();
         else cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
